// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants and state encodings for the PS/2 scan-code encoder.
//   PS2_BREAK   : set-2 release prefix byte
//   PS2_EXT     : set-2 extended-key prefix byte
//   PS2_RESEND  : host command asking the device to repeat its last byte
//   ACK_TIMEOUT : cycles the TX FSM waits for the controller to go busy
//   tx_state_t  : one-hot TX FSM states
//   enc_state_t : encoder byte-sequencer states
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam int         ACK_TIMEOUT = 4;

    typedef enum logic [4:0] {
        TX_IDLE      = 5'b00001,
        TX_ISSUE     = 5'b00010,
        TX_WAIT_ACK  = 5'b00100,
        TX_WAIT_DONE = 5'b01000,
        TX_CHECK     = 5'b10000
    } tx_state_t;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_EXT,
        ENC_BRK,
        ENC_CODE
    } enc_state_t;

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo
// Single-clock byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are told apart without a separate occupancy counter.
// Ports:
//   clock_quarter, reset : clock and synchronous active-high reset
//   push, din            : write din when not full
//   pop                  : drop the head byte when not empty
//   dout                 : current head byte (combinational read)
//   empty, full          : occupancy flags
//   free_cnt             : number of free slots (0..DEPTH)
module ps2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock_quarter,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] used;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign used     = wr_ptr - rd_ptr;
    assign free_cnt = DEPTH_W - used;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign dout     = mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty gates every read of stale contents.
    always_ff @(posedge clock_quarter) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_scan_encoder.sv
// ps2_scan_encoder
// Turns key make/break events into PS/2 set-2 byte sequences, queues them in
// a byte FIFO and hands them one at a time to the PS/2 bus controller,
// retrying failed bytes and re-issuing bytes pre-empted by host traffic.
// Optional feature macro: PS2_RESEND_EN adds host_resend, which repeats the
// last successfully sent byte ahead of the FIFO contents.
// Ports:
//   clock_quarter, reset          : clock, synchronous active-high reset
//   key_valid/key_code/key_ext/key_break : key event, key_ready = accepted
//   bus_tx_ready/bus_tx_faild/bus_rx_complete : controller status
//   bus_enable, bus_tx_data       : one-cycle send request and its byte
//   drop                          : pulse, byte given up after MAX_RETRY
//   overflow                      : sticky, event arrived while not ready
//   busy                          : FIFO non-empty or transfer in flight
//   host_resend (PS2_RESEND_EN)   : pulse when host sent 0xFE
module ps2_scan_encoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clock_quarter,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_break,
    output logic       key_ready,
    input  logic       bus_tx_ready,
    input  logic       bus_tx_faild,
    input  logic       bus_rx_complete,
`ifdef PS2_RESEND_EN
    input  logic       host_resend,
`endif
    output logic       bus_enable,
    output logic [7:0] bus_tx_data,
    output logic       drop,
    output logic       overflow,
    output logic       busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MIN_FREE = 3;
    localparam logic [2:0] MAX_RETRY_W = MAX_RETRY[2:0];
    localparam logic [1:0] ACK_LAST = 2'(ACK_TIMEOUT - 1);

    enc_state_t    enc_state;
    enc_state_t    enc_next;
    logic [7:0]    code_q;
    logic          break_q;
    logic          accept;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_din;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] free_cnt;

    tx_state_t     tx_state;
    tx_state_t     tx_next;
    logic [7:0]    data_next;
    logic [2:0]    retry_cnt;
    logic [2:0]    retry_next;
    logic [1:0]    wait_cnt;
    logic [1:0]    wait_next;
    logic          host_seen;
    logic          seen_next;
    logic          drop_next;

    logic          resend_req;
    logic          resend_active;
    logic [7:0]    resend_byte;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_quarter (clock_quarter),
        .reset         (reset),
        .push          (fifo_push),
        .pop           (fifo_pop),
        .din           (fifo_din),
        .dout          (fifo_dout),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .free_cnt      (free_cnt)
    );

    // Three free slots guarantee the longest sequence (E0 F0 code) fits.
    assign key_ready = (enc_state == ENC_IDLE) && (free_cnt >= MIN_FREE) && !fifo_full;
    assign accept    = key_valid && key_ready;

    // Encoder registers: latch the event fields on acceptance and record
    // any event that arrives while the encoder cannot take it.
    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            enc_state <= ENC_IDLE;
            code_q    <= '0;
            break_q   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            enc_state <= enc_next;
            if (accept) begin
                code_q  <= key_code;
                break_q <= key_break;
            end
            if (key_valid && !key_ready) overflow <= 1'b1;
        end
    end

    // Encoder sequencer: one byte pushed per cycle, prefixes first.
    always_comb begin
        enc_next  = enc_state;
        fifo_push = 1'b0;
        fifo_din  = code_q;
        unique case (enc_state)
            ENC_IDLE: begin
                if (accept) begin
                    if (key_ext)        enc_next = ENC_EXT;
                    else if (key_break) enc_next = ENC_BRK;
                    else                enc_next = ENC_CODE;
                end
            end
            ENC_EXT: begin
                fifo_push = 1'b1;
                fifo_din  = PS2_EXT;
                enc_next  = break_q ? ENC_BRK : ENC_CODE;
            end
            ENC_BRK: begin
                fifo_push = 1'b1;
                fifo_din  = PS2_BREAK;
                enc_next  = ENC_CODE;
            end
            ENC_CODE: begin
                fifo_push = 1'b1;
                fifo_din  = code_q;
                enc_next  = ENC_IDLE;
            end
            default: enc_next = ENC_IDLE;
        endcase
    end

    // TX state and datapath registers. bus_tx_data holds the byte in flight
    // from ISSUE to CHECK so retries and re-issues resend the same value.
    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            bus_tx_data <= '0;
            retry_cnt   <= '0;
            wait_cnt    <= '0;
            host_seen   <= 1'b0;
            drop        <= 1'b0;
        end else begin
            tx_state    <= tx_next;
            bus_tx_data <= data_next;
            retry_cnt   <= retry_next;
            wait_cnt    <= wait_next;
            host_seen   <= seen_next;
            drop        <= drop_next;
        end
    end

    // TX next-state logic. A host read during WAIT_DONE means the controller
    // never sent our byte, so it goes straight back to ISSUE without
    // touching the retry count. A pending resend overrides the FIFO head and
    // never pops the FIFO.
    always_comb begin
        tx_next    = tx_state;
        data_next  = bus_tx_data;
        retry_next = retry_cnt;
        wait_next  = wait_cnt;
        seen_next  = host_seen;
        drop_next  = 1'b0;
        fifo_pop   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (bus_tx_ready) begin
                    if (resend_req) begin
                        tx_next   = TX_ISSUE;
                        data_next = resend_byte;
                    end else if (!fifo_empty) begin
                        tx_next   = TX_ISSUE;
                        data_next = fifo_dout;
                    end
                end
            end
            TX_ISSUE: begin
                tx_next   = TX_WAIT_ACK;
                wait_next = '0;
            end
            TX_WAIT_ACK: begin
                if (!bus_tx_ready) begin
                    tx_next   = TX_WAIT_DONE;
                    seen_next = 1'b0;
                end else if (wait_cnt == ACK_LAST) begin
                    tx_next = TX_ISSUE;
                end else begin
                    wait_next = wait_cnt + 2'd1;
                end
            end
            TX_WAIT_DONE: begin
                if (bus_tx_ready) begin
                    tx_next   = (host_seen || bus_rx_complete) ? TX_ISSUE : TX_CHECK;
                    seen_next = 1'b0;
                end else if (bus_rx_complete) begin
                    seen_next = 1'b1;
                end
            end
            TX_CHECK: begin
                if (!bus_tx_faild) begin
                    fifo_pop   = !resend_active;
                    retry_next = '0;
                    tx_next    = TX_IDLE;
                end else if (retry_cnt < MAX_RETRY_W) begin
                    retry_next = retry_cnt + 3'd1;
                    tx_next    = TX_ISSUE;
                end else begin
                    fifo_pop   = !resend_active;
                    drop_next  = 1'b1;
                    retry_next = '0;
                    tx_next    = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

`ifdef PS2_RESEND_EN
    logic       resend_pend;
    logic [7:0] last_tx;
    logic       xfer_end;
    logic       xfer_ok;
    logic       resend_start;

    assign xfer_end     = (tx_state == TX_CHECK) && (tx_next == TX_IDLE);
    assign xfer_ok      = xfer_end && !bus_tx_faild;
    assign resend_start = (tx_state == TX_IDLE) && (tx_next == TX_ISSUE) && resend_req;
    assign resend_req   = resend_pend;
    assign resend_byte  = last_tx;

    // Resend bookkeeping: a host request stays pending until the repeated
    // byte finishes; a request arriving mid-transfer simply waits for IDLE.
    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            resend_pend   <= 1'b0;
            resend_active <= 1'b0;
            last_tx       <= '0;
        end else begin
            if (xfer_ok) last_tx <= bus_tx_data;
            if (resend_start)  resend_active <= 1'b1;
            else if (xfer_end) resend_active <= 1'b0;
            if (host_resend)                   resend_pend <= 1'b1;
            else if (resend_active && xfer_end) resend_pend <= 1'b0;
        end
    end
`else
    assign resend_req    = 1'b0;
    assign resend_active = 1'b0;
    assign resend_byte   = 8'h00;
`endif

    assign bus_enable = (tx_state == TX_ISSUE);
    assign busy       = !fifo_empty || (tx_state != TX_IDLE);

endmodule

// File: tb/tb_ps2_scan_encoder.sv
// tb_ps2_scan_encoder
// Directed bench for ps2_scan_encoder with a behavioural bus-controller model
// that logs every issued byte and can fail, ignore or pre-empt transfers.
module tb_ps2_scan_encoder;

    logic       clock_quarter = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ext = 1'b0;
    logic       key_break = 1'b0;
    logic       key_ready;
    logic       bus_tx_ready = 1'b1;
    logic       bus_tx_faild = 1'b0;
    logic       bus_rx_complete = 1'b0;
    logic       bus_enable;
    logic [7:0] bus_tx_data;
    logic       drop;
    logic       overflow;
    logic       busy;
`ifdef PS2_RESEND_EN
    logic       host_resend = 1'b0;
`endif

    int         vectors = 0;
    int         miscompares = 0;

    int         fail_until = 0;
    int         rx_on = -1;
    int         ignore_on = -1;
    logic       bm_stall = 1'b0;
    int         bm_enables = 0;
    int         bm_cnt = 0;
    int         bm_cur = 0;
    logic [7:0] issued[$];
    int         drop_cnt = 0;

    typedef struct {
        logic            ext;
        logic            brk;
        logic [7:0]      code;
        int              nbytes;
        logic [0:2][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    ps2_scan_encoder #(
        .FIFO_DEPTH (16),
        .MAX_RETRY  (3)
    ) dut (
        .clock_quarter   (clock_quarter),
        .reset           (reset),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .key_ext         (key_ext),
        .key_break       (key_break),
        .key_ready       (key_ready),
        .bus_tx_ready    (bus_tx_ready),
        .bus_tx_faild    (bus_tx_faild),
        .bus_rx_complete (bus_rx_complete),
`ifdef PS2_RESEND_EN
        .host_resend     (host_resend),
`endif
        .bus_enable      (bus_enable),
        .bus_tx_data     (bus_tx_data),
        .drop            (drop),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clock_quarter = ~clock_quarter;

    // Bus controller model: a send keeps tx_ready low for four cycles, then
    // reports failure for transfers numbered below fail_until. Transfer
    // rx_on gets a host-read pulse mid-flight; transfer ignore_on is never
    // acknowledged.
    always @(negedge clock_quarter) begin
        bus_rx_complete = 1'b0;
        if (reset) begin
            bm_cnt       = 0;
            bus_tx_ready = 1'b1;
            bus_tx_faild = 1'b0;
        end else if (bm_cnt > 0) begin
            bm_cnt--;
            if (bm_cnt == 2 && bm_cur == rx_on) bus_rx_complete = 1'b1;
            if (bm_cnt == 0) begin
                bus_tx_ready = 1'b1;
                bus_tx_faild = (bm_cur < fail_until);
            end
        end else if (bus_enable) begin
            issued.push_back(bus_tx_data);
            bm_cur = bm_enables;
            bm_enables++;
            if (bm_cur != ignore_on) begin
                bm_cnt       = 4;
                bus_tx_ready = 1'b0;
            end
        end else begin
            bus_tx_ready = !bm_stall;
        end
    end

    // Count drop pulses away from the active edge.
    always @(negedge clock_quarter) begin
        if (!reset && drop) drop_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one key event for a single cycle and report how many cycles
    // key_ready then stayed low (bounded).
    task automatic applyStimulus(input logic ext, input logic brk, input logic [7:0] code, output int low_cycles);
        @(negedge clock_quarter);
        key_ext   = ext;
        key_break = brk;
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clock_quarter);
        #1;
        key_valid = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_quarter);
            if (key_ready) break;
            low_cycles++;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge clock_quarter);
        while (busy && n < 400) begin
            @(negedge clock_quarter);
            n++;
        end
        checkOutput({name, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] loggedByte(input int idx);
        if (idx < issued.size()) return {24'b0, issued[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int base;
        int low;
        int d0;

        vecs[0] = '{1'b0, 1'b0, 8'h1C, 1, {8'h1C, 8'h00, 8'h00}};
        vecs[1] = '{1'b0, 1'b1, 8'h1C, 2, {8'hF0, 8'h1C, 8'h00}};
        vecs[2] = '{1'b1, 1'b0, 8'h75, 2, {8'hE0, 8'h75, 8'h00}};
        vecs[3] = '{1'b1, 1'b1, 8'h75, 3, {8'hE0, 8'hF0, 8'h75}};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1, {8'h00, 8'h00, 8'h00}};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 2, {8'hF0, 8'hFF, 8'h00}};

        // Reset values
        repeat (3) @(posedge clock_quarter);
        @(negedge clock_quarter);
        checkOutput("rst key_ready", {31'b0, key_ready}, 32'd1);
        checkOutput("rst bus_enable", {31'b0, bus_enable}, 32'd0);
        checkOutput("rst bus_tx_data", {24'b0, bus_tx_data}, 32'd0);
        checkOutput("rst drop", {31'b0, drop}, 32'd0);
        checkOutput("rst overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock_quarter);

        // Table: each event's byte sequence, key_ready hold-off, no drops
        for (int v = 0; v < 6; v++) begin
            base = issued.size();
            d0   = drop_cnt;
            applyStimulus(vecs[v].ext, vecs[v].brk, vecs[v].code, low);
            checkOutput($sformatf("v%0d ready_low", v), low, vecs[v].nbytes);
            waitIdle($sformatf("v%0d", v));
            checkOutput($sformatf("v%0d count", v), issued.size() - base, vecs[v].nbytes);
            for (int k = 0; k < vecs[v].nbytes; k++)
                checkOutput($sformatf("v%0d byte%0d", v, k), loggedByte(base + k), {24'b0, vecs[v].exp[k]});
            checkOutput($sformatf("v%0d drop", v), drop_cnt - d0, 0);
        end

        // Controller never acknowledges: byte re-issued after the timeout
        base = issued.size();
        d0   = drop_cnt;
        ignore_on = bm_enables;
        applyStimulus(1'b0, 1'b0, 8'h33, low);
        waitIdle("ack_to");
        checkOutput("ack_to count", issued.size() - base, 2);
        checkOutput("ack_to byte0", loggedByte(base), 32'h33);
        checkOutput("ack_to byte1", loggedByte(base + 1), 32'h33);
        checkOutput("ack_to drop", drop_cnt - d0, 0);

        // Four failures of 1C: four issues, one drop, then 2A
        base = issued.size();
        d0   = drop_cnt;
        fail_until = bm_enables + 4;
        applyStimulus(1'b0, 1'b0, 8'h1C, low);
        applyStimulus(1'b0, 1'b0, 8'h2A, low);
        waitIdle("retry");
        checkOutput("retry count", issued.size() - base, 5);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("retry byte%0d", k), loggedByte(base + k), 32'h1C);
        checkOutput("retry next", loggedByte(base + 4), 32'h2A);
        checkOutput("retry drop", drop_cnt - d0, 1);

        // Host read pre-empts 2A, then three failures: a counted pre-emption
        // would exhaust the retries and drop the byte
        base = issued.size();
        d0   = drop_cnt;
        rx_on      = bm_enables;
        fail_until = bm_enables + 4;
        applyStimulus(1'b0, 1'b0, 8'h2A, low);
        waitIdle("rx");
        checkOutput("rx count", issued.size() - base, 5);
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("rx byte%0d", k), loggedByte(base + k), 32'h2A);
        checkOutput("rx drop", drop_cnt - d0, 0);

        // Fill the FIFO with the bus stalled
        bm_stall = 1'b1;
        repeat (2) @(negedge clock_quarter);
        base = issued.size();
        for (int i = 0; i < 14; i++) begin
            checkOutput($sformatf("fill ready%0d", i), {31'b0, key_ready}, 32'd1);
            applyStimulus(1'b0, 1'b0, 8'h40 + 8'(i), low);
            if (i < 13) checkOutput($sformatf("fill low%0d", i), low, 1);
        end
        checkOutput("full ready", {31'b0, key_ready}, 32'd0);
        checkOutput("full ovf pre", {31'b0, overflow}, 32'd0);
        checkOutput("full issued", issued.size() - base, 0);
        @(negedge clock_quarter);
        key_code  = 8'h99;
        key_valid = 1'b1;
        @(posedge clock_quarter);
        #1;
        key_valid = 1'b0;
        @(negedge clock_quarter);
        checkOutput("ovf set", {31'b0, overflow}, 32'd1);
        bm_stall = 1'b0;
        waitIdle("drain");
        checkOutput("drain count", issued.size() - base, 14);
        for (int k = 0; k < 14; k++)
            checkOutput($sformatf("drain byte%0d", k), loggedByte(base + k), 32'h40 + k);
        checkOutput("ovf sticky", {31'b0, overflow}, 32'd1);

        // Reset clears the sticky overflow
        @(negedge clock_quarter);
        reset = 1'b1;
        repeat (2) @(negedge clock_quarter);
        reset = 1'b0;
        @(negedge clock_quarter);
        checkOutput("rst2 overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst2 key_ready", {31'b0, key_ready}, 32'd1);
        checkOutput("rst2 busy", {31'b0, busy}, 32'd0);

`ifdef PS2_RESEND_EN
        // Host resend: 5A repeated ahead of the queued 1C, 1C still sent once
        applyStimulus(1'b0, 1'b0, 8'h5A, low);
        waitIdle("rs first");
        bm_stall = 1'b1;
        repeat (2) @(negedge clock_quarter);
        base = issued.size();
        applyStimulus(1'b0, 1'b0, 8'h1C, low);
        @(negedge clock_quarter);
        host_resend = 1'b1;
        @(negedge clock_quarter);
        host_resend = 1'b0;
        bm_stall = 1'b0;
        waitIdle("rs");
        checkOutput("rs count", issued.size() - base, 2);
        checkOutput("rs byte0", loggedByte(base), 32'h5A);
        checkOutput("rs byte1", loggedByte(base + 1), 32'h1C);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
